// File: rtl/primitive_unit.sv
// primitive_unit: shared primitive-AABB store for the ray-tracing pipeline.
// It holds up to NUM_PRIMITIVES bounding boxes, loaded through a single write
// port. It serves two query ports, each with one slot per ray core. Each slot
// returns a window of up to AABB_TEST_UNIT_SIZE consecutive primitives, with
// one cycle of latency and fully registered outputs.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset (outputs only)
//   prim_we/waddr/wdata     primitive load port
//   q{0,1}_valid/start/count per-core query: valid, start index, entry count
//   p{0,1}                  per-core, per-entry AABB results ([core][entry])
//   p{0,1}_valid            per-entry valid flags
module primitive_unit #(
   parameter int unsigned RAY_CORE_SIZE       = 4,
   parameter int unsigned AABB_TEST_UNIT_SIZE = 4,
   parameter int unsigned NUM_PRIMITIVES      = 64,
   parameter int unsigned IDX_W               = $clog2(NUM_PRIMITIVES),
   parameter int unsigned COORD_W             = 32,
   parameter int unsigned AABB_W              = 6*COORD_W
) (
   input  logic                                                    clk,
   input  logic                                                    reset_n,
   input  logic                                                    prim_we,
   input  logic [IDX_W-1:0]                                        prim_waddr,
   input  logic [AABB_W-1:0]                                       prim_wdata,
   input  logic [RAY_CORE_SIZE-1:0]                                q0_valid,
   input  logic [RAY_CORE_SIZE*IDX_W-1:0]                          q0_start,
   input  logic [RAY_CORE_SIZE*($clog2(AABB_TEST_UNIT_SIZE)+1)-1:0] q0_count,
   input  logic [RAY_CORE_SIZE-1:0]                                q1_valid,
   input  logic [RAY_CORE_SIZE*IDX_W-1:0]                          q1_start,
   input  logic [RAY_CORE_SIZE*($clog2(AABB_TEST_UNIT_SIZE)+1)-1:0] q1_count,
   output logic [RAY_CORE_SIZE*AABB_TEST_UNIT_SIZE*AABB_W-1:0]     p0,
   output logic [RAY_CORE_SIZE*AABB_TEST_UNIT_SIZE-1:0]            p0_valid,
   output logic [RAY_CORE_SIZE*AABB_TEST_UNIT_SIZE*AABB_W-1:0]     p1,
   output logic [RAY_CORE_SIZE*AABB_TEST_UNIT_SIZE-1:0]            p1_valid
);

   localparam int unsigned CNT_W  = $clog2(AABB_TEST_UNIT_SIZE) + 1;
   localparam int unsigned SLOTS  = RAY_CORE_SIZE * AABB_TEST_UNIT_SIZE;
   localparam int unsigned DATA_W = SLOTS * AABB_W;
   localparam logic [IDX_W:0] NPRIM = (IDX_W+1)'(NUM_PRIMITIVES);

   // The AABB word must hold exactly six coordinates.
   if (AABB_W != 6*COORD_W) begin : g_bad_aabb_w
      $error("primitive_unit: AABB_W must equal 6*COORD_W");
   end

   // Primitive storage. It has no reset, so contents survive reset_n.
   logic [AABB_W-1:0] r_mem [NUM_PRIMITIVES];

   // Both query ports as arrays, so one loop serves them.
   logic [RAY_CORE_SIZE-1:0]       w_qv [2];
   logic [RAY_CORE_SIZE*IDX_W-1:0] w_qs [2];
   logic [RAY_CORE_SIZE*CNT_W-1:0] w_qc [2];
   logic [DATA_W-1:0]              w_d  [2];
   logic [SLOTS-1:0]               w_v  [2];
   logic [IDX_W:0]                 w_idx;
   logic [CNT_W-1:0]               w_cnt;

   logic [DATA_W-1:0] r_p0, r_p1;
   logic [SLOTS-1:0]  r_p0_vld, r_p1_vld;

   assign w_qv[0] = q0_valid;
   assign w_qv[1] = q1_valid;
   assign w_qs[0] = q0_start;
   assign w_qs[1] = q1_start;
   assign w_qc[0] = q0_count;
   assign w_qc[1] = q1_count;

   // Load port. Out-of-range addresses are dropped (non-power-of-two depth).
   always_ff @(posedge clk) begin
      if (prim_we && ({1'b0, prim_waddr} < NPRIM)) begin
         r_mem[prim_waddr] <= prim_wdata;
      end
   end

   // Window lookup for every (port, core, entry).
   // The index is one bit wider than IDX_W, so windows never wrap past the end.
   // Because j < AABB_TEST_UNIT_SIZE always holds, j < count also clamps
   // oversized counts.
   always_comb begin
      w_d[0] = '0;
      w_d[1] = '0;
      w_v[0] = '0;
      w_v[1] = '0;
      w_idx  = '0;
      w_cnt  = '0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < int'(RAY_CORE_SIZE); i++) begin
            for (int j = 0; j < int'(AABB_TEST_UNIT_SIZE); j++) begin
               w_idx = {1'b0, w_qs[p][i*IDX_W +: IDX_W]} + (IDX_W+1)'(j);
               w_cnt = w_qc[p][i*CNT_W +: CNT_W];
               if (w_qv[p][i] && (CNT_W'(j) < w_cnt) && (w_idx < NPRIM)) begin
                  w_v[p][i*AABB_TEST_UNIT_SIZE + j] = 1'b1;
                  w_d[p][(i*AABB_TEST_UNIT_SIZE + j)*AABB_W +: AABB_W] =
                     r_mem[w_idx[IDX_W-1:0]];
               end
            end
         end
      end
   end

   // Output registers. Reset clears them at once and drops any in-flight query.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_p0     <= '0;
         r_p1     <= '0;
         r_p0_vld <= '0;
         r_p1_vld <= '0;
      end else begin
         r_p0     <= w_d[0];
         r_p1     <= w_d[1];
         r_p0_vld <= w_v[0];
         r_p1_vld <= w_v[1];
      end
   end

   assign p0       = r_p0;
   assign p1       = r_p1;
   assign p0_valid = r_p0_vld;
   assign p1_valid = r_p1_vld;

endmodule

// File: tb/tb_primitive_unit.sv
// tb_primitive_unit: scoreboard bench for primitive_unit.
// It keeps its own copy of memory. Each cycle it predicts the outputs when it
// drives the inputs, queues the prediction, and compares it after the next edge.
module tb_primitive_unit;

   localparam int NC = 4;
   localparam int NT = 4;
   localparam int NP = 64;
   localparam int IW = 6;
   localparam int CW = 3;
   localparam int AW = 192;

   typedef struct packed {
      logic [2*NC*NT-1:0]    v;
      logic [2*NC*NT*AW-1:0] d;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                prim_we;
   logic [IW-1:0]       prim_waddr;
   logic [AW-1:0]       prim_wdata;
   logic [NC-1:0]       q0_valid, q1_valid;
   logic [NC*IW-1:0]    q0_start, q1_start;
   logic [NC*CW-1:0]    q0_count, q1_count;
   logic [NC*NT*AW-1:0] p0, p1;
   logic [NC*NT-1:0]    p0_valid, p1_valid;

   logic [AW-1:0] mdl [NP];
   exp_t          sb [$];
   int            n_pass  = 0;
   int            n_total = 0;
   logic [AW-1:0] a_val, b_val;

   primitive_unit dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .prim_we    (prim_we),
      .prim_waddr (prim_waddr),
      .prim_wdata (prim_wdata),
      .q0_valid   (q0_valid),
      .q0_start   (q0_start),
      .q0_count   (q0_count),
      .q1_valid   (q1_valid),
      .q1_start   (q1_start),
      .q1_count   (q1_count),
      .p0         (p0),
      .p0_valid   (p0_valid),
      .p1         (p1),
      .p1_valid   (p1_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      n_total++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   function automatic logic [AW-1:0] mk(input int k);
      return {$urandom, $urandom, $urandom, $urandom, $urandom, 32'(k)};
   endfunction

   task automatic clear_q();
      prim_we = 1'b0; prim_waddr = '0; prim_wdata = '0;
      q0_valid = '0; q0_start = '0; q0_count = '0;
      q1_valid = '0; q1_start = '0; q1_count = '0;
   endtask

   task automatic set_q(input int p, input int i, input bit v, input int s, input int c);
      if (p == 0) begin
         q0_valid[i] = v; q0_start[i*IW +: IW] = IW'(s); q0_count[i*CW +: CW] = CW'(c);
      end else begin
         q1_valid[i] = v; q1_start[i*IW +: IW] = IW'(s); q1_count[i*CW +: CW] = CW'(c);
      end
   endtask

   task automatic wr(input int a, input logic [AW-1:0] d);
      prim_we = 1'b1; prim_waddr = IW'(a); prim_wdata = d;
   endtask

   task automatic check_all_zero(input string tag);
      for (int s = 0; s < NC*NT; s++) begin
         check($sformatf("%s_p0d%0d", tag, s), p0[s*AW +: AW], '0);
         check($sformatf("%s_p1d%0d", tag, s), p1[s*AW +: AW], '0);
      end
      check($sformatf("%s_p0v", tag), AW'(p0_valid), '0);
      check($sformatf("%s_p1v", tag), AW'(p1_valid), '0);
   endtask

   // Predict from the current inputs and the pre-write memory, clock once, then compare.
   task automatic step();
      exp_t e;
      bit   v;
      int   s, c, idx, k;
      e = '0;
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < NC; i++)
            for (int j = 0; j < NT; j++) begin
               v = (p == 0) ? q0_valid[i] : q1_valid[i];
               s = (p == 0) ? int'(q0_start[i*IW +: IW]) : int'(q1_start[i*IW +: IW]);
               c = (p == 0) ? int'(q0_count[i*CW +: CW]) : int'(q1_count[i*CW +: CW]);
               idx = s + j;
               k = (p*NC + i)*NT + j;
               if (v && j < c && idx < NP) begin
                  e.v[k] = 1'b1;
                  e.d[k*AW +: AW] = mdl[idx];
               end
            end
      sb.push_back(e);
      if (prim_we) mdl[prim_waddr] = prim_wdata;
      @(posedge clk); #1;
      prim_we = 1'b0;
      e = sb.pop_front();
      for (int i = 0; i < NC; i++)
         for (int j = 0; j < NT; j++) begin
            k = i*NT + j;
            check($sformatf("p0[%0d][%0d].v", i, j), AW'(p0_valid[k]), AW'(e.v[k]));
            check($sformatf("p0[%0d][%0d].d", i, j), p0[k*AW +: AW], e.d[k*AW +: AW]);
            check($sformatf("p1[%0d][%0d].v", i, j), AW'(p1_valid[k]), AW'(e.v[NC*NT + k]));
            check($sformatf("p1[%0d][%0d].d", i, j), p1[k*AW +: AW], e.d[(NC*NT + k)*AW +: AW]);
         end
   endtask

   initial begin
      reset_n = 1'b0;
      clear_q();
      set_q(0, 0, 1, 0, 4);
      set_q(1, 3, 1, 5, 2);
      #3 check_all_zero("rst_async");
      @(posedge clk); @(posedge clk); #1;
      check_all_zero("rst_hold");
      @(negedge clk);
      reset_n = 1'b1;
      clear_q();

      // First query after reset release.
      wr(0, mk(0));
      step();
      set_q(0, 0, 1, 0, 1);
      step();
      check("first_minx", AW'(p0[31:0]), AW'(0));
      check("first_v", AW'(p0_valid[0]), AW'(1));
      clear_q();

      // Load the whole array, MinX = index.
      for (int k = 0; k < NP; k++) begin
         wr(k, mk(k));
         step();
      end

      // Basic window: core 1, port 0, start 2, count 3.
      set_q(0, 1, 1, 2, 3);
      step();
      check("win_e0_minx", AW'(p0[(1*NT+0)*AW +: 32]), AW'(2));
      check("win_e2_minx", AW'(p0[(1*NT+2)*AW +: 32]), AW'(4));
      check("win_e3_v", AW'(p0_valid[1*NT+3]), AW'(0));
      clear_q();

      // Array end, no wrap. Oversized count is clamped.
      set_q(0, 0, 1, 62, 4);
      set_q(1, 2, 1, 10, 7);
      set_q(1, 3, 1, 63, 1);
      step();
      check("end_v", AW'(p0_valid[3:0]), AW'(4'b0011));
      check("clamp_v", AW'(p1_valid[2*NT +: NT]), AW'(4'b1111));
      clear_q();

      // Read-before-write collision.
      a_val = mdl[5];
      b_val = mk(500);
      wr(5, b_val);
      set_q(0, 0, 1, 5, 1);
      step();
      check("coll_old", p0[AW-1:0], a_val);
      step();
      check("coll_new", p0[AW-1:0], b_val);
      clear_q();

      // Identical windows on every slot, then distinct windows.
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < NC; i++) set_q(p, i, 1, 20, 4);
      step();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < NC; i++) set_q(p, i, 1, 8*(p*NC + i), 4);
      step();

      // Back-to-back random traffic with random writes.
      for (int n = 0; n < 40; n++) begin
         for (int p = 0; p < 2; p++)
            for (int i = 0; i < NC; i++)
               set_q(p, i, 1'($urandom_range(0, 1)), int'($urandom_range(0, NP-1)),
                     int'($urandom_range(0, 7)));
         if ($urandom_range(0, 1) == 1) wr(int'($urandom_range(0, NP-1)), mk(int'($urandom)));
         step();
      end
      clear_q();

      // Invalid queries: valid low with data, or count 0.
      set_q(1, 1, 0, 7, 3);
      set_q(1, 2, 1, 9, 0);
      set_q(0, 1, 1, 7, 3);
      step();
      check("inv_v", AW'(p1_valid[1*NT +: 2*NT]), AW'(0));
      clear_q();

      // Reset asserted mid-operation.
      set_q(0, 0, 1, 0, 4);
      step();
      set_q(0, 0, 1, 8, 4);
      @(negedge clk);
      reset_n = 1'b0;
      #1 check_all_zero("rst_mid");
      @(posedge clk); #1;
      check_all_zero("rst_mid_hold");
      @(negedge clk);
      reset_n = 1'b1;
      clear_q();
      step();
      set_q(0, 0, 1, 0, 4);
      set_q(1, 0, 1, 60, 4);
      step();
      clear_q();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
